// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared across the PWM blocks.
//   pwm_tb_state_e - timebase FSM states (IDLE / RUN)
//   DEF_CNT_WIDTH  - default counter, period and duty width
//   clamp_period   - lower clamp applied to a requested period
// The compare and dead-time stages import this package as well.
package pwm_pkg;

  localparam int DEF_CNT_WIDTH = 32;
  // Width of clamp_period's arguments. Callers zero-extend into this width
  // and truncate the result back, so any CNT_WIDTH up to 64 works.
  localparam int PWM_MAX_W = 64;

  typedef enum logic {
    TB_IDLE = 1'b0,
    TB_RUN  = 1'b1
  } pwm_tb_state_e;

  function automatic logic [PWM_MAX_W-1:0] clamp_period(
    input logic [PWM_MAX_W-1:0] p,
    input logic [PWM_MAX_W-1:0] min_p
  );
    return (p < min_p) ? min_p : p;
  endfunction

endpackage

// File: rtl/pwm_timebase_if.sv
// pwm_timebase_if: control and status bundle of the PWM timebase.
//   master - the controller: drives enable and the configuration strobe, reads status
//   slave  - the timebase: reads the controls, drives cnt, effective config and flags
interface pwm_timebase_if
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic                 enable;
  logic [CNT_WIDTH-1:0] period_cycles;
  logic [CNT_WIDTH-1:0] duty_cycles;
  logic                 cfg_update;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] period_cycles_eff;
  logic [CNT_WIDTH-1:0] duty_cycles_sh;
  logic                 period_start;
  logic                 period_end;
  logic                 cfg_pending;
  logic                 running;

  modport master (
    output enable, period_cycles, duty_cycles, cfg_update,
    input  cnt, period_cycles_eff, duty_cycles_sh, period_start, period_end,
           cfg_pending, running
  );

  modport slave (
    input  enable, period_cycles, duty_cycles, cfg_update,
    output cnt, period_cycles_eff, duty_cycles_sh, period_start, period_end,
           cfg_pending, running
  );
endinterface

// File: rtl/pwm_cfg_shadow.sv
// pwm_cfg_shadow: staging plus active registers for the period and duty.
//   clk, rst_n    - clock, asynchronous active-low reset
//   cfg_update    - strobe capturing period_cycles / duty_cycles
//   period_cycles - requested period (clamped here on capture)
//   duty_cycles   - requested duty (passed through unsaturated)
//   boundary      - from the FSM: high in IDLE or on the RUN wrap cycle
//   period_eff    - active clamped period
//   duty_sh       - active duty
//   cfg_pending   - a staged value is waiting for a boundary
module pwm_cfg_shadow
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MIN_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_update,
  input  logic [CNT_WIDTH-1:0] period_cycles,
  input  logic [CNT_WIDTH-1:0] duty_cycles,
  input  logic                 boundary,
  output logic [CNT_WIDTH-1:0] period_eff,
  output logic [CNT_WIDTH-1:0] duty_sh,
  output logic                 cfg_pending
);

  localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);

  logic [CNT_WIDTH-1:0] stg_period;
  logic [CNT_WIDTH-1:0] stg_duty;
  logic [CNT_WIDTH-1:0] period_clamped;

  assign period_clamped =
    CNT_WIDTH'(clamp_period(PWM_MAX_W'(period_cycles), PWM_MAX_W'(MIN_PERIOD)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_period  <= MIN_P;
      stg_duty    <= '0;
      period_eff  <= MIN_P;
      duty_sh     <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_update) begin
        stg_period <= period_clamped;
        stg_duty   <= duty_cycles;
      end
      if (boundary) begin
        // A strobe on the boundary itself bypasses staging and supersedes
        // whatever was staged earlier.
        if (cfg_update) begin
          period_eff  <= period_clamped;
          duty_sh     <= duty_cycles;
          cfg_pending <= 1'b0;
        end else if (cfg_pending) begin
          period_eff  <= stg_period;
          duty_sh     <= stg_duty;
          cfg_pending <= 1'b0;
        end
      end else if (cfg_update) begin
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// pwm_timebase: free-running PWM period counter with shadowed configuration.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - pwm_timebase_if.slave:
//                in : enable, period_cycles, duty_cycles, cfg_update
//                out: cnt, period_cycles_eff, duty_cycles_sh, period_start,
//                     period_end, cfg_pending, running
// The counter runs 0..period_cycles_eff-1. New configuration takes effect
// only at a period boundary, or immediately while idle.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int MIN_PERIOD = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_timebase_if.slave  bus
);

  pwm_tb_state_e        state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 running;
  logic [CNT_WIDTH-1:0] period_eff;
  logic [CNT_WIDTH-1:0] duty_sh;
  logic                 cfg_pending;
  logic                 wrap;
  logic                 boundary;

  // period_eff >= 1 always, so the subtraction cannot underflow, and
  // cnt < period_eff keeps the compare inside CNT_WIDTH.
  assign wrap     = (state == TB_RUN) && (cnt == period_eff - CNT_WIDTH'(1));
  assign boundary = (state == TB_IDLE) || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TB_IDLE;
      cnt     <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        TB_IDLE: begin
          cnt <= '0;
          if (bus.enable) begin
            state   <= TB_RUN;
            running <= 1'b1;
          end
        end
        TB_RUN: begin
          if (!bus.enable) begin
            state   <= TB_IDLE;
            running <= 1'b0;
            cnt     <= '0;
          end else if (wrap) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state   <= TB_IDLE;
          running <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  pwm_cfg_shadow #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_shadow (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_update    (bus.cfg_update),
    .period_cycles (bus.period_cycles),
    .duty_cycles   (bus.duty_cycles),
    .boundary      (boundary),
    .period_eff    (period_eff),
    .duty_sh       (duty_sh),
    .cfg_pending   (cfg_pending)
  );

  // Decoded from registers only; no input reaches these flags.
  assign bus.period_start      = running && (cnt == '0);
  assign bus.period_end        = running && (cnt == period_eff - CNT_WIDTH'(1));
  assign bus.cnt               = cnt;
  assign bus.running           = running;
  assign bus.period_cycles_eff = period_eff;
  assign bus.duty_cycles_sh    = duty_sh;
  assign bus.cfg_pending       = cfg_pending;

endmodule

// File: tb/tb_pwm_timebase.sv
module tb_pwm_timebase;
  localparam int W    = 16;
  localparam int MINP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pwm_timebase_if #(.CNT_WIDTH(W)) bus ();

  pwm_timebase #(.CNT_WIDTH(W), .MIN_PERIOD(MINP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Rules: the boundary is "idle" or "last count of the period"; a strobe on
  // a boundary commits directly, a staged value commits on the next boundary,
  // and the count advances modulo the period that was active in that cycle.
  bit m_run = 0;
  int m_cnt = 0, m_eff = MINP, m_duty = 0, m_sp = MINP, m_sd = 0;
  bit m_pend = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_eff = MINP; m_duty = 0;
      m_sp = MINP; m_sd = 0; m_pend = 0;
    end else begin
      bit bnd;
      int cp, old_eff;
      bnd     = !m_run || (m_cnt == m_eff - 1);
      cp      = (int'(bus.period_cycles) < MINP) ? MINP : int'(bus.period_cycles);
      old_eff = m_eff;
      if (bus.cfg_update && bnd) begin
        m_eff = cp; m_duty = int'(bus.duty_cycles); m_pend = 0;
      end else if (bnd && m_pend) begin
        m_eff = m_sp; m_duty = m_sd; m_pend = 0;
      end else if (bus.cfg_update) begin
        m_pend = 1;
      end
      if (bus.cfg_update) begin
        m_sp = cp; m_sd = int'(bus.duty_cycles);
      end
      m_cnt = (m_run && bus.enable) ? (m_cnt + 1) % old_eff : 0;
      m_run = bus.enable;
    end
  end

  // One compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("m_cnt",     bus.cnt, m_cnt);
    chk("m_eff",     bus.period_cycles_eff, m_eff);
    chk("m_duty",    bus.duty_cycles_sh, m_duty);
    chk("m_pending", bus.cfg_pending, m_pend);
    chk("m_running", bus.running, m_run);
    chk("m_start",   bus.period_start, m_run && m_cnt == 0);
    chk("m_end",     bus.period_end, m_run && m_cnt == m_eff - 1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic upd(input int p, input int d);
    bus.period_cycles = W'(p);
    bus.duty_cycles   = W'(d);
    bus.cfg_update    = 1'b1;
    tick();
    bus.cfg_update    = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int budget = 40;
    while (int'(bus.cnt) != v && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("wait_cnt_timeout", bus.cnt, v);
  endtask

  initial begin
    bus.enable = 0; bus.period_cycles = '0; bus.duty_cycles = '0; bus.cfg_update = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_eff", bus.period_cycles_eff, 2);
    chk("rst_duty", bus.duty_cycles_sh, 0);
    chk("rst_pending", bus.cfg_pending, 0);
    chk("rst_running", bus.running, 0);
    rst_n = 1'b1;
    tick();

    // Period 5 loaded while idle, then run: 0,1,2,3,4,0
    upd(5, 2);
    chk("idle_eff", bus.period_cycles_eff, 5);
    chk("idle_duty", bus.duty_cycles_sh, 2);
    chk("idle_pending", bus.cfg_pending, 0);
    bus.enable = 1; tick();
    chk("en_running", bus.running, 1);
    chk("p5_cnt0", bus.cnt, 0);
    chk("p5_start", bus.period_start, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("p5_cnt", bus.cnt, i);
    end
    chk("p5_end", bus.period_end, 1);
    tick();
    chk("p5_wrap", bus.cnt, 0);
    chk("p5_start2", bus.period_start, 1);

    // Clamp: period 0 and 1 both become 2
    bus.enable = 0; tick();
    upd(0, 0); chk("clamp0", bus.period_cycles_eff, 2);
    upd(1, 0); chk("clamp1", bus.period_cycles_eff, 2);
    bus.enable = 1; tick();
    chk("p2_c0", bus.cnt, 0); tick();
    chk("p2_c1", bus.cnt, 1); tick();
    chk("p2_c2", bus.cnt, 0);

    // Period 8, update (4,3) at cnt 2 stays pending until the wrap
    bus.enable = 0; tick();
    upd(8, 0);
    bus.enable = 1; tick(); tick(); tick();
    chk("p8_at2", bus.cnt, 2);
    upd(4, 3);
    chk("pend_set", bus.cfg_pending, 1);
    chk("pend_eff_old", bus.period_cycles_eff, 8);
    repeat (4) tick();
    chk("pend_at7", bus.cnt, 7);
    chk("pend_hold", bus.cfg_pending, 1);
    tick();
    chk("commit_cnt", bus.cnt, 0);
    chk("commit_eff", bus.period_cycles_eff, 4);
    chk("commit_duty", bus.duty_cycles_sh, 3);
    chk("commit_pend", bus.cfg_pending, 0);

    // Two strobes in one period: last wins
    upd(6, 0); upd(10, 0); tick(); tick();
    chk("lastwins_cnt", bus.cnt, 0);
    chk("lastwins_eff", bus.period_cycles_eff, 10);

    // Strobe exactly on the wrap cycle of period 8
    upd(8, 0);
    wait_cnt(0);
    chk("p8b_eff", bus.period_cycles_eff, 8);
    wait_cnt(7);
    upd(3, 0);
    chk("wrapupd_cnt", bus.cnt, 0);
    chk("wrapupd_eff", bus.period_cycles_eff, 3);
    chk("wrapupd_pend", bus.cfg_pending, 0);
    tick(); tick();
    chk("p3_end", bus.period_end, 1);

    // Disable at cnt 3 with a pending update: commits in IDLE
    upd(8, 0);
    chk("p8c_eff", bus.period_cycles_eff, 8);
    wait_cnt(2);
    upd(5, 7);
    chk("dis_at3", bus.cnt, 3);
    bus.enable = 0; tick();
    chk("dis_running", bus.running, 0);
    chk("dis_cnt", bus.cnt, 0);
    chk("dis_pend", bus.cfg_pending, 1);
    tick();
    chk("dis_eff", bus.period_cycles_eff, 5);
    chk("dis_duty", bus.duty_cycles_sh, 7);
    chk("dis_pend_clr", bus.cfg_pending, 0);

    // Asynchronous reset mid-period with a pending update
    bus.enable = 1; tick(); tick(); tick();
    upd(9, 1);
    chk("ar_pend", bus.cfg_pending, 1);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("ar_cnt", bus.cnt, 0);
    chk("ar_eff", bus.period_cycles_eff, 2);
    chk("ar_duty", bus.duty_cycles_sh, 0);
    chk("ar_pend0", bus.cfg_pending, 0);
    chk("ar_running", bus.running, 0);
    chk("ar_end", bus.period_end, 0);
    tick(); rst_n = 1'b1; tick();

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.enable        = ($urandom_range(0, 19) != 0);
      bus.cfg_update    = ($urandom_range(0, 5) == 0);
      bus.period_cycles = W'($urandom_range(0, 12));
      bus.duty_cycles   = W'($urandom);
      tick();
    end
    bus.cfg_update = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pwm_timebase.md
# pwm_timebase

Free-running PWM period counter that sits directly upstream of the PWM compare stage. It produces the counter `cnt`, which runs from 0 to `period_cycles_eff-1`, along with the clamped effective period and a glitch-free shadowed duty value. Configuration changes are staged and committed only at a period boundary, so the compare stage never sees a period or duty change mid-cycle.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of the counter, period and duty buses.
- `MIN_PERIOD`, 2, lower clamp for the effective period; legal range 1 to 2^CNT_WIDTH-1.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  run the counter; low holds the counter idle.
- `period_cycles`  in  CNT_WIDTH  requested period in clk cycles; any value accepted.
- `duty_cycles`  in  CNT_WIDTH  requested duty in clk cycles; passed through unsaturated.
- `cfg_update`  in  1  single-cycle strobe that captures `period_cycles` and `duty_cycles` into staging.
- `cnt`  out  CNT_WIDTH  current count (registered).
- `period_cycles_eff`  out  CNT_WIDTH  active clamped period (registered).
- `duty_cycles_sh`  out  CNT_WIDTH  active shadowed duty (registered).
- `period_start`  out  1  high while `cnt==0` and running.
- `period_end`  out  1  high while `cnt==period_cycles_eff-1` and running.
- `cfg_pending`  out  1  staged configuration is waiting for a boundary.
- `running`  out  1  FSM is in RUN.

## Operation
- Clamp rule: clamp(p) = (p < MIN_PERIOD) ? MIN_PERIOD : p. It is applied at capture, so the staging and active periods are always >= MIN_PERIOD.
- FSM states are IDLE and RUN.
- IDLE behaviour:
  - `cnt`=0; `period_start`=0 and `period_end`=0.
  - `cfg_update` commits directly to the active registers on the next edge; `cfg_pending` stays 0.
  - A staged value left pending from RUN is committed on the first IDLE cycle.
- IDLE→RUN: when `enable`=1. The first RUN cycle has `cnt`=0.
- RUN behaviour:
  - `cnt` increments by 1 each cycle.
  - When `cnt==period_cycles_eff-1` (the wrap cycle), the next `cnt` is 0.
  - The comparison uses the full CNT_WIDTH with no overflow, because `cnt < period_cycles_eff` always holds.
- RUN→IDLE: when `enable`=0. `cnt` becomes 0 on the next edge. The active period and duty are retained.
- Staging:
  - `cfg_update` captures clamp(`period_cycles`) and `duty_cycles` into the staging registers and sets `cfg_pending`.
  - A repeat strobe while pending overwrites the staging registers (last write wins).
- Commit in RUN: at the wrap edge, if `cfg_pending`=1, staging is copied to active and `cfg_pending` clears. The new values are visible from the following `cnt`=0 cycle.
- Simultaneous `cfg_update` and wrap cycle: the strobed input values commit directly at that wrap, superseding any older staged values, and `cfg_pending` ends at 0.
- Simultaneous `cfg_update` and `enable` falling: the update is captured, then commits on the first IDLE cycle.
- Duty is not saturated here; saturation belongs to the compare stage.

## Timing
Reset values (asynchronous, effective while `rst_n`=0):
- FSM = IDLE; `cnt`=0; `period_cycles_eff`=MIN_PERIOD; `duty_cycles_sh`=0.
- Staging period = MIN_PERIOD; staging duty = 0; `cfg_pending`=0; `running`=0.

Latencies:
- `enable` rise to `running`=1 and `cnt`=0: 1 clk.
- `enable` fall to `running`=0: 1 clk.
- `cfg_update` to `cfg_pending`: 1 clk.
- `cfg_update` in IDLE to active outputs: 1 clk.
- `period_start` and `period_end` are combinational from registered state only, with no path from any input.
- Period length: in steady state, `period_end` pulses every `period_cycles_eff` clocks. With `period_cycles_eff`=1 (only possible if MIN_PERIOD=1), `cnt` stays at 0 and `period_start` and `period_end` are both high every cycle.
- Reset mid-period: asynchronous return to reset values. No commit of staged data occurs.

## Structure
- Shared package `pwm_pkg` holds:
  - typedef `pwm_tb_state_e` {TB_IDLE, TB_RUN};
  - the default `CNT_WIDTH` constant;
  - a `clamp_period` function.
  The compare stage and a future dead-time stage reuse the package.
- Natural sub-module: `pwm_cfg_shadow`, which contains the staging registers, the pending flag and the commit/bypass mux, with the commit strobe driven by the FSM. The counter and FSM stay in `pwm_timebase`.

## Test plan
- Reset with `period_cycles`=5, `enable`=1 and one `cfg_update` in IDLE → `cnt` sequence 0,1,2,3,4,0; `period_end` high at `cnt`=4; `period_start` high at `cnt`=0.
- `period_cycles`=0 and then 1 with MIN_PERIOD=2 → `period_cycles_eff`=2; `cnt` toggles 0,1.
- Running with period 8; `cfg_update` with period 4, duty 3 at `cnt`=2 → `cfg_pending` high until the wrap at `cnt`=7; then `period_cycles_eff`=4 and `duty_cycles_sh`=3 from the next `cnt`=0.
- Two `cfg_update` strobes (period 6, then period 10) within one period → only 10 is committed at the wrap.
- `cfg_update` with period 3 exactly on a wrap cycle of period 8 → the next period is 3 and `cfg_pending`=0 after that edge.
- Deassert `enable` at `cnt`=3 with an update pending, and assert `rst_n`=0 mid-period in a separate run → pending update commits in IDLE and `cnt`=0; reset returns all outputs to their reset values immediately, without waiting for a clk edge.
